frame_capture: RTL and testbench
================================

// Module: frame_capture
//
// PURPOSE
//  Downstream consumer of the vsync controller's sync_sig/finished pair. Samples the
//  camera byte bus (href, din) on clk only while sync_sig frames exactly one image.
//  Packs byte pairs into 16-bit RGB565 words and writes them sequentially into the
//  frame buffer. Reports capture_done once the frame closes.
//
// PARAMETERS
//  H_PIXELS  640  pixels (16-bit words) per line
//  V_LINES   480  lines per frame
//  ADDR_W    19   frame-buffer word-address width; must satisfy 2^ADDR_W >= H_PIXELS*V_LINES
//
// PORTS
//  clk           in   1       pixel clock; sole clock, all logic on posedge
//  reset         in   1       synchronous, active-high
//  sync_sig      in   1       frame window from vsync controller (registered on clk)
//  finished      in   1       vsync controller one-shot done; while 1, no new frame is armed
//  href          in   1       line-valid from camera
//  din           in   8       camera data byte
//  wr_en         out  1       1-cycle write strobe to frame buffer
//  wr_addr       out  ADDR_W  word address of current write
//  wr_data       out  16      {first_byte, second_byte}
//  line_cnt      out  10      completed lines in current/last frame
//  capturing     out  1       1 while in CAPTURE state
//  capture_done  out  1       sticky; set on frame close, cleared only by reset
//  overflow      out  1       sticky; word attempted beyond H_PIXELS*V_LINES-1
//
// BEHAVIOUR
//  - Reset: every output is 0; state=IDLE; byte phase=0; address=0; sync_sig_d=0.
//  - Reset asserted mid-frame aborts the capture immediately; no further writes occur.
//  - sync_sig_d is the one-cycle delayed copy of sync_sig, used for edge detection.
//  - FSM IDLE -> CAPTURE: on sync_sig=1 && sync_sig_d=0 (rising edge) and capture_done=0.
//  - sync_sig already high at reset release does not start a capture; a rising edge is required.
//  - FSM CAPTURE -> DONE: on sync_sig=0 && sync_sig_d=1. In that cycle capture_done<=1.
//  - DONE is terminal until reset. finished=1 also blocks IDLE->CAPTURE.
//  - Packing (CAPTURE only): on each edge with href=1:
//      - phase 0: latch din as hi byte, phase<=1.
//      - phase 1: wr_data<={hi,din}, wr_en<=1, phase<=0.
//  - Write latency: wr_en is high for exactly the cycle after the second byte is sampled.
//  - wr_addr holds the write address during wr_en and increments by 1 on the following edge.
//  - wr_en, wr_addr and wr_data are all registered.
//  - href falling edge (href=0, href_d=1) in CAPTURE: phase<=0 and line_cnt<=line_cnt+1.
//    An odd trailing byte is discarded.
//  - Address limit: when a word would land at address >= H_PIXELS*V_LINES:
//      - wr_en stays 0, overflow<=1, and the address saturates.
//  - Frame close while phase=1: the pending byte is discarded. No wr_en occurs in DONE.
//  - Simultaneous href fall and sync_sig fall: line_cnt still increments, and the FSM enters DONE.
//  - Outside CAPTURE, href and din are ignored entirely.
//
// CONFIGURATION
//  - FRAME_CAPTURE_GEOM_CHECK_EN defined:
//      - adds output geom_err (1 bit, reset 0, sticky).
//      - geom_err is set when any line closes with a word count != H_PIXELS.
//      - geom_err is also set when the frame closes with line_cnt != V_LINES.
//  - Not defined: port absent, no per-line counter is synthesized.
//  - All other behaviour is identical in both builds.
//
// STRUCTURE
//  - Package frame_capture_pkg holds:
//      - the state encoding (IDLE=2'd0, CAPTURE=2'd1, DONE=2'd2);
//      - the localparam FRAME_WORDS = H_PIXELS*V_LINES;
//      - the line-count width (10).
//  - Sub-module byte_packer:
//      - inputs: clk, reset, en, href, din;
//      - outputs: word_vld, word;
//      - owns the phase bit and the hi-byte register; cleared on href fall or en=0.
//  - Top level owns the FSM, the edge detectors, the address/line counters and the flags.
//
// TESTING
//  - Basic frame: set H_PIXELS=4, V_LINES=2. Drive one sync_sig pulse enclosing 2 lines of 8 bytes.
//    Expect exactly 8 wr_en pulses, addr 0..7, and wr_data[0]=16'hA1B2 from bytes A1,B2.
//    Expect line_cnt=2 and capture_done=1.
//  - Latency: a byte pair sampled at edges n and n+1 gives wr_en=1 only in the cycle after edge n+1.
//    wr_addr is stable during that cycle.
//  - Odd line: a line of 7 bytes gives 3 writes. The next line restarts at phase 0 with the hi byte.
//  - Overflow: a frame of 3 lines x 8 bytes with H=4,V=2 gives 8 writes then overflow=1.
//    wr_addr holds at 7 and no wr_en occurs after address 7.
//  - Re-arm and start blocking:
//      - after DONE, a second sync_sig pulse gives no writes;
//      - sync_sig high at reset release gives no capture until it falls and rises again.
//  - Reset mid-frame: assert reset after 3 writes. All outputs are 0 on the next cycle.
//    The remaining frame bytes produce no wr_en.
//  - Geometry check (FRAME_CAPTURE_GEOM_CHECK_EN): a 6-byte line with H=4 sets geom_err=1
//    at that line's href fall.

Source files
------------

// File: rtl/frame_capture_pkg.sv
// Shared types and constants for the frame capture block.
package frame_capture_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } cap_state_t;

    localparam int DEF_H_PIXELS = 640;
    localparam int DEF_V_LINES  = 480;
    localparam int FRAME_WORDS  = DEF_H_PIXELS * DEF_V_LINES;
    localparam int LINE_CNT_W   = 10;

    function automatic int frame_words(input int h_pixels, input int v_lines);
        return h_pixels * v_lines;
    endfunction

endpackage

// File: rtl/frame_capture_byte_packer.sv
// Pairs camera bytes into 16-bit words; word_vld is combinational on the second byte.
module byte_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        href,
    input  logic [7:0]  din,
    output logic        word_vld,
    output logic [15:0] word
);

    logic       phase;
    logic       href_d;
    logic [7:0] hi_byte;
    logic       href_fall;

    assign href_fall = !href && href_d;

    // A line end or leaving the capture window drops any half-assembled word.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase   <= 1'b0;
            hi_byte <= 8'd0;
            href_d  <= 1'b0;
        end else begin
            href_d <= href;
            if (!en || href_fall) begin
                phase <= 1'b0;
            end else if (href) begin
                if (!phase) begin
                    hi_byte <= din;
                    phase   <= 1'b1;
                end else begin
                    phase <= 1'b0;
                end
            end
        end
    end

    assign word_vld = en && href && phase;
    assign word     = {hi_byte, din};

endmodule

// File: rtl/frame_capture.sv
// Single-frame RGB565 capture into a frame buffer.
// Optional FRAME_CAPTURE_GEOM_CHECK_EN adds the sticky geom_err output.
module frame_capture
    import frame_capture_pkg::*;
#(
    parameter int H_PIXELS = 640,
    parameter int V_LINES  = 480,
    parameter int ADDR_W   = 19
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sync_sig,
    input  logic                  finished,
    input  logic                  href,
    input  logic [7:0]            din,
    output logic                  wr_en,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [15:0]           wr_data,
    output logic [LINE_CNT_W-1:0] line_cnt,
    output logic                  capturing,
    output logic                  capture_done,
`ifdef FRAME_CAPTURE_GEOM_CHECK_EN
    output logic                  geom_err,
`endif
    output logic                  overflow
);

    localparam int                FRAME_LIMIT = frame_words(H_PIXELS, V_LINES);
    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(FRAME_LIMIT - 1);

    cap_state_t  state;
    cap_state_t  next_state;
    logic        sync_sig_d;
    logic        href_d;
    logic        seen_low;
    logic        full;
    logic        sync_rise;
    logic        sync_fall;
    logic        href_fall;
    logic        pack_en;
    logic        word_vld;
    logic [15:0] word;

    assign sync_rise = sync_sig && !sync_sig_d;
    assign sync_fall = !sync_sig && sync_sig_d;
    assign href_fall = !href && href_d;
    assign pack_en   = capturing && sync_sig;

    byte_packer u_packer (
        .clk      (clk),
        .reset    (reset),
        .en       (pack_en),
        .href     (href),
        .din      (din),
        .word_vld (word_vld),
        .word     (word)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // A start needs a genuine low-to-high window edge seen after reset.
    always_comb begin
        next_state = state;
        capturing  = 1'b0;
        case (state)
            IDLE: begin
                if (sync_rise && seen_low && !capture_done && !finished)
                    next_state = CAPTURE;
            end
            CAPTURE: begin
                capturing = 1'b1;
                if (sync_fall) next_state = DONE;
            end
            DONE:    next_state = DONE;
            default: next_state = IDLE;
        endcase
    end

    // full marks the last address as written so later words raise overflow
    // instead of rewriting the saturated address.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_sig_d   <= 1'b0;
            href_d       <= 1'b0;
            seen_low     <= !sync_sig;
            full         <= 1'b0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= 16'd0;
            line_cnt     <= '0;
            capture_done <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            sync_sig_d <= sync_sig;
            href_d     <= href;
            wr_en      <= 1'b0;
            if (!sync_sig) seen_low <= 1'b1;
            if (wr_en && wr_addr != LAST_ADDR) wr_addr <= wr_addr + 1'b1;
            if (word_vld) begin
                if (!full) begin
                    wr_en   <= 1'b1;
                    wr_data <= word;
                    if (wr_addr == LAST_ADDR) full <= 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end
            if (capturing && href_fall) line_cnt <= line_cnt + 1'b1;
            if (capturing && sync_fall) capture_done <= 1'b1;
        end
    end

`ifdef FRAME_CAPTURE_GEOM_CHECK_EN
    localparam int LW_W = $clog2(H_PIXELS + 2);

    logic [LW_W-1:0]       line_words;
    logic [LINE_CNT_W-1:0] lines_at_close;

    assign lines_at_close = href_fall ? line_cnt + 1'b1 : line_cnt;

    // The word counter saturates one past a full line so long lines stay flagged.
    always_ff @(posedge clk) begin
        if (reset) begin
            line_words <= '0;
            geom_err   <= 1'b0;
        end else begin
            if (capturing && href_fall) begin
                line_words <= '0;
                if (line_words != LW_W'(H_PIXELS)) geom_err <= 1'b1;
            end else if (word_vld && line_words != LW_W'(H_PIXELS + 1)) begin
                line_words <= line_words + 1'b1;
            end
            if (capturing && sync_fall && lines_at_close != LINE_CNT_W'(V_LINES))
                geom_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_frame_capture.sv
// Randomized self-checking bench for frame_capture (H_PIXELS=4, V_LINES=2).
module tb_frame_capture;

    localparam int H     = 4;
    localparam int V     = 2;
    localparam int AW    = 3;
    localparam int FRAME = H * V;

    typedef struct {
        int          addr;
        logic [15:0] data;
        int          at_edge;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          sync_sig;
    logic          finished;
    logic          href;
    logic [7:0]    din;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;
    logic [9:0]    line_cnt;
    logic          capturing;
    logic          capture_done;
    logic          overflow;
`ifdef FRAME_CAPTURE_GEOM_CHECK_EN
    logic          geom_err;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    int   edge_cnt = 0;
    bit   mon_on   = 1'b0;
    exp_t exp_q[$];

    int m_words;
    int m_lines;
    bit m_over;
    bit m_done;
    bit m_geom;

    frame_capture #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .sync_sig     (sync_sig),
        .finished     (finished),
        .href         (href),
        .din          (din),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .line_cnt     (line_cnt),
        .capturing    (capturing),
        .capture_done (capture_done),
`ifdef FRAME_CAPTURE_GEOM_CHECK_EN
        .geom_err     (geom_err),
`endif
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Every cycle: a write must appear exactly when the model scheduled one.
    always @(negedge clk) begin
        if (mon_on) begin
            bit   exp_now;
            exp_t e;
            exp_now = (exp_q.size() > 0) && (exp_q[0].at_edge == edge_cnt);
            checkOutput("wr_en", wr_en, exp_now);
            if (exp_now) begin
                e = exp_q.pop_front();
                checkOutput("wr_addr", wr_addr, e.addr);
                checkOutput("wr_data", wr_data, e.data);
            end
        end
    end

    task automatic drive(input logic s, input logic h, input logic [7:0] d);
        sync_sig = s;
        href     = h;
        din      = d;
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        checkOutput({tag, "_wr_en"}, wr_en, 0);
        checkOutput({tag, "_wr_addr"}, wr_addr, 0);
        checkOutput({tag, "_wr_data"}, wr_data, 0);
        checkOutput({tag, "_line_cnt"}, line_cnt, 0);
        checkOutput({tag, "_capturing"}, capturing, 0);
        checkOutput({tag, "_done"}, capture_done, 0);
        checkOutput({tag, "_overflow"}, overflow, 0);
`ifdef FRAME_CAPTURE_GEOM_CHECK_EN
        checkOutput({tag, "_geom_err"}, geom_err, 0);
`endif
    endtask

    task automatic clear_model();
        m_words = 0;
        m_lines = 0;
        m_over  = 0;
        m_done  = 0;
        m_geom  = 0;
        exp_q.delete();
    endtask

    task automatic reset_dut(input logic s);
        reset    = 1'b1;
        sync_sig = s;
        href     = 1'b0;
        din      = 8'd0;
        finished = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset  = 1'b0;
        mon_on = 1'b1;
        clear_model();
        check_idle("reset");
        drive(s, 1'b0, 8'd0);
    endtask

    // One sync_sig pulse around up to three lines; live says whether the
    // DUT is expected to accept this frame at all.
    task automatic applyStimulus(input int l0, input int l1, input int l2,
                                 input bit live, input bit fixed_first);
        int         lens[3];
        int         nlines;
        int         line_words;
        int         exp_addr;
        logic [7:0] b;
        logic [7:0] prev;
        lens   = '{l0, l1, l2};
        nlines = (l2 > 0) ? 3 : (l1 > 0) ? 2 : 1;
        prev   = 8'd0;
        drive(1'b1, 1'b0, 8'd0);
        checkOutput("capturing_start", capturing, live);
        for (int l = 0; l < nlines; l++) begin
            line_words = 0;
            for (int i = 0; i < lens[l]; i++) begin
                if (fixed_first && l == 0 && i < 2) b = (i == 0) ? 8'hA1 : 8'hB2;
                else                                b = 8'($urandom);
                if (live && (i % 2 == 1)) begin
                    line_words++;
                    if (m_words < FRAME) begin
                        exp_q.push_back('{m_words, {prev, b}, edge_cnt + 1});
                        m_words++;
                    end else begin
                        m_over = 1;
                    end
                end
                prev = b;
                drive(1'b1, 1'b1, b);
            end
            drive(1'b1, 1'b0, 8'd0);
            if (live) begin
                m_lines++;
                if (line_words != H) m_geom = 1;
            end
`ifdef FRAME_CAPTURE_GEOM_CHECK_EN
            checkOutput("geom_line", geom_err, m_geom);
`endif
            drive(1'b1, 1'b0, 8'd0);
        end
        drive(1'b0, 1'b0, 8'd0);
        if (live) begin
            m_done = 1;
            if (m_lines != V) m_geom = 1;
        end
        exp_addr = (m_words < FRAME) ? m_words : FRAME - 1;
        checkOutput("capture_done", capture_done, m_done);
        checkOutput("line_cnt", line_cnt, m_lines);
        checkOutput("overflow", overflow, m_over);
        checkOutput("capturing_end", capturing, 0);
`ifdef FRAME_CAPTURE_GEOM_CHECK_EN
        checkOutput("geom_err", geom_err, m_geom);
`endif
        drive(1'b0, 1'b0, 8'd0);
        checkOutput("final_addr", wr_addr, exp_addr);
        checkOutput("pending", exp_q.size(), 0);
    endtask

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [7:0] b;
        logic [7:0] prev;
        reset    = 1'b1;
        sync_sig = 1'b0;
        finished = 1'b0;
        href     = 1'b0;
        din      = 8'd0;
        @(negedge clk);

        $display("[TB] basic frame, then a second pulse after DONE");
        reset_dut(1'b0);
        applyStimulus(8, 8, 0, 1'b1, 1'b1);
        applyStimulus(8, 0, 0, 1'b0, 1'b0);

        $display("[TB] odd-length line");
        reset_dut(1'b0);
        applyStimulus(7, 8, 0, 1'b1, 1'b0);

        $display("[TB] overflow frame");
        reset_dut(1'b0);
        applyStimulus(8, 8, 8, 1'b1, 1'b0);

        $display("[TB] sync_sig high at reset release, then a real frame");
        reset_dut(1'b1);
        applyStimulus(8, 8, 0, 1'b0, 1'b0);
        applyStimulus(8, 8, 0, 1'b1, 1'b0);

        $display("[TB] finished blocks arming");
        reset_dut(1'b0);
        finished = 1'b1;
        applyStimulus(6, 0, 0, 1'b0, 1'b0);
        finished = 1'b0;
        applyStimulus(8, 8, 0, 1'b1, 1'b0);

        $display("[TB] reset mid-frame");
        reset_dut(1'b0);
        prev = 8'd0;
        drive(1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom);
            if (i % 2 == 1) begin
                exp_q.push_back('{m_words, {prev, b}, edge_cnt + 1});
                m_words++;
            end
            prev = b;
            drive(1'b1, 1'b1, b);
        end
        reset = 1'b1;
        drive(1'b1, 1'b1, 8'h55);
        reset = 1'b0;
        check_idle("midreset");
        checkOutput("midreset_pending", exp_q.size(), 0);
        clear_model();
        for (int i = 0; i < 8; i++) drive(1'b1, (i % 3) != 2, 8'($urandom));
        drive(1'b0, 1'b0, 8'd0);
        drive(1'b0, 1'b0, 8'd0);
        checkOutput("midreset_capturing", capturing, 0);
        checkOutput("midreset_done", capture_done, 0);
        checkOutput("midreset_addr", wr_addr, 0);

        $display("[TB] randomized frames");
        for (int k = 0; k < 8; k++) begin
            int n;
            int l0;
            int l1;
            int l2;
            n  = $urandom_range(1, 3);
            l0 = $urandom_range(1, 10);
            l1 = (n > 1) ? $urandom_range(1, 10) : 0;
            l2 = (n > 2) ? $urandom_range(1, 10) : 0;
            reset_dut(1'b0);
            applyStimulus(l0, l1, l2, 1'b1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
